// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point helpers for the PageRank engine.
// The helpers work on 32-bit containers; callers pass the active word width.
package pagerank_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, DONE} state_t;

  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Top w bits of a*b*c, where the full product spans 3*w bits.
  function automatic logic [31:0] frac_mul3(input logic [32:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input int unsigned w);
    logic [127:0] p;
    p = {95'd0, a} * {96'd0, b} * {96'd0, c};
    p = p >> (2 * w);
    return 32'(p) & width_mask(w);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, width_mask(w)}) ? width_mask(w) : 32'(s);
  endfunction

  function automatic logic [31:0] init_rank(input int unsigned n, input int unsigned w);
    logic [32:0] one;
    one = 33'd1 << w;
    return 32'(one / 33'(n));
  endfunction

endpackage

// File: rtl/pagerank_iter_mac.sv
// Register-free multiply-accumulate step: acc + top(db*w*v), saturating.
module pr_mac
  import pagerank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             en_i,
  input  logic             adj_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH:0]   db_i,
  input  logic [WIDTH-1:0] w_i,
  input  logic [WIDTH-1:0] v_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    if (en_i && adj_i)
      acc_o = WIDTH'(sat_add(32'(acc_i), frac_mul3(33'(db_i), 32'(w_i), 32'(v_i), WIDTH), WIDTH));
  end

endmodule

// File: rtl/pagerank_iter.sv
// Iterative PageRank engine: one adjacency entry per cycle, Jacobi update,
// convergence on max |delta| <= tol or iteration limit.
module pagerank_iter
  import pagerank_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(N),
  parameter int ITW   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N*N-1:0]     adjacency,
  input  logic [N*WIDTH-1:0] weights,
  input  logic [WIDTH-1:0]   damping,
  input  logic [WIDTH-1:0]   tol,
  input  logic [ITW-1:0]     max_iter,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [ITW-1:0]     iter_count,
  input  logic [IDXW-1:0]    rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  localparam logic [WIDTH-1:0] INIT_RANK = WIDTH'(init_rank(N, WIDTH));

  state_t             state_q;
  logic [N*N-1:0]     adj_q;
  logic [N*WIDTH-1:0] w_q;
  logic [WIDTH-1:0]   d_q, tol_q, acc_q, maxd_q;
  logic [ITW-1:0]     maxit_q, iter_q;
  logic [WIDTH-1:0]   rank_q [N];
  logic [WIDTH-1:0]   next_q [N];
  logic [IDXW-1:0]    j_q, k_q;
  logic               busy_q, done_q, conv_q;

  logic [WIDTH-1:0]   dn, acc_d, rank_j, delta;
  logic [WIDTH:0]     db;
  logic [ITW-1:0]     eff_max;
  logic               last_iter;

  assign dn        = d_q >> IDXW;
  assign db        = {1'b1, {WIDTH{1'b0}}} - {1'b0, d_q};
  assign rank_j    = rank_q[j_q];
  assign delta     = (acc_d >= rank_j) ? (acc_d - rank_j) : (rank_j - acc_d);
  assign eff_max   = (maxit_q == '0) ? ITW'(1) : maxit_q;
  assign last_iter = ({1'b0, iter_q} + (ITW+1)'(1)) >= {1'b0, eff_max};

  // Row-major walk: {j,k} is exactly j*N+k because N is a power of two.
  pr_mac #(.WIDTH(WIDTH)) u_mac (
    .en_i  (state_q == ACCUM),
    .adj_i (adj_q[{j_q, k_q}]),
    .acc_i (acc_q),
    .db_i  (db),
    .w_i   (w_q[k_q*WIDTH +: WIDTH]),
    .v_i   (rank_q[k_q]),
    .acc_o (acc_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adj_q   <= '0;
      w_q     <= '0;
      d_q     <= '0;
      tol_q   <= '0;
      maxit_q <= '0;
      acc_q   <= '0;
      maxd_q  <= '0;
      iter_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        rank_q[i] <= INIT_RANK;
        next_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            adj_q   <= adjacency;
            w_q     <= weights;
            d_q     <= damping;
            tol_q   <= tol;
            maxit_q <= max_iter;
            for (int i = 0; i < N; i++) rank_q[i] <= INIT_RANK;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= damping >> IDXW;
            maxd_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          k_q <= k_q + IDXW'(1);
          if (k_q == IDXW'(N-1)) begin
            next_q[j_q] <= acc_d;
            if (delta > maxd_q) maxd_q <= delta;
            acc_q <= dn;
            j_q   <= j_q + IDXW'(1);
            if (j_q == IDXW'(N-1)) state_q <= COMMIT;
          end else begin
            acc_q <= acc_d;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N; i++) rank_q[i] <= next_q[i];
          iter_q <= iter_q + ITW'(1);
          if (maxd_q <= tol_q || last_iter) begin
            conv_q  <= (maxd_q <= tol_q);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            maxd_q  <= '0;
            state_q <= ACCUM;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign rd_data    = rank_q[rd_addr];

endmodule

// File: tb/tb_pagerank_iter.sv
// Scoreboard bench for pagerank_iter (N=4, WIDTH=16): a plain-arithmetic
// PageRank model predicts each run; a monitor checks every done pulse.
module tb_pagerank_iter;
  localparam int N = 4, W = 16, IW = 2, ITW = 8, NN = N * N;

  logic             clk, reset_n, start;
  logic [NN-1:0]    adjacency;
  logic [N*W-1:0]   weights;
  logic [W-1:0]     damping, tol;
  logic [ITW-1:0]   max_iter;
  logic             busy, done, converged;
  logic [ITW-1:0]   iter_count;
  logic [IW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;

  pagerank_iter #(.N(N), .WIDTH(W), .IDXW(IW), .ITW(ITW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .adjacency(adjacency),
    .weights(weights), .damping(damping), .tol(tol), .max_iter(max_iter),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0, miscompares = 0;

  typedef struct {
    int             iters;
    bit             conv;
    logic [N*W-1:0] ranks;
    int             start_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: straight PageRank iteration with the fixed-point rules.
  task automatic model(input logic [NN-1:0] a, input logic [N*W-1:0] wv, input int d,
                       input int tl, input int mi, output exp_t e);
    longint unsigned r[N], nx[N];
    longint unsigned acc, t, dd, md, db;
    int eff;
    eff = (mi == 0) ? 1 : mi;
    db  = 65536 - d;
    for (int i = 0; i < N; i++) r[i] = 65536 / N;
    e.iters = 0;
    e.conv  = 1'b0;
    for (int it = 1; it <= eff; it++) begin
      md = 0;
      for (int j = 0; j < N; j++) begin
        acc = d / N;
        for (int k = 0; k < N; k++) begin
          if (a[j*N+k]) begin
            t = (db * longint'(wv[k*W +: W]) * r[k]) >> (2 * W);
            acc = acc + t;
            if (acc > 65535) acc = 65535;
          end
        end
        nx[j] = acc;
        dd = (acc > r[j]) ? acc - r[j] : r[j] - acc;
        if (dd > md) md = dd;
      end
      for (int i = 0; i < N; i++) r[i] = nx[i];
      e.iters = it;
      if (md <= longint'(tl)) begin
        e.conv = 1'b1;
        break;
      end
    end
    for (int i = 0; i < N; i++) e.ranks[i*W +: W] = W'(r[i]);
  endtask

  task automatic run(input logic [NN-1:0] a, input logic [N*W-1:0] wv, input int d,
                     input int tl, input int mi);
    exp_t e;
    int   c;
    model(a, wv, d, tl, mi, e);
    @(negedge clk);
    adjacency = a; weights = wv; damping = W'(d); tol = W'(tl); max_iter = ITW'(mi);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.start_cyc = cyc;
    sb.push_back(e);
    // inputs are registered at start, so scramble them while busy
    adjacency = NN'($urandom); weights = {$urandom, $urandom}; damping = W'($urandom);
    c = 0;
    while (sb.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: done not seen within %0d cycles", c);
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: done=1, expected no done pulse");
        end else begin
          e = sb.pop_front();
          chk("done_latency", 64'(cyc - e.start_cyc), 64'(e.iters * (NN + 1)));
          chk("iter_count", 64'(iter_count), 64'(e.iters));
          chk("converged", 64'(converged), 64'(e.conv));
          chk("busy_in_done", 64'(busy), 64'd0);
          for (int i = 0; i < N; i++) begin
            rd_addr = IW'(i);
            #1;
            chk("rank", 64'(rd_data), 64'(e.ranks[i*W +: W]));
          end
        end
      end
    end
  end

  initial begin : stim
    reset_n = 1'b0; start = 1'b0; adjacency = '0; weights = '0;
    damping = '0; tol = '0; max_iter = '0; rd_addr = '0;
    #13;
    for (int i = 0; i < N; i++) begin
      rd_addr = IW'(i);
      #1;
      chk("reset_rank", 64'(rd_data), 64'h4000);
    end
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_conv", 64'(converged), 64'd0);
    chk("reset_iter", 64'(iter_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run('0, {4{16'h4000}}, 'h2666, 0, 10);
    #1; rd_addr = 2'd2; #1;
    chk("empty_graph_rank", 64'(rd_data), 64'h0999);
    run('0, {4{16'h4000}}, 'h2666, 0, 1);
    run('1, {4{16'hFFFF}}, 0, 0, 2);
    #1; rd_addr = 2'd1; #1;
    chk("saturated_rank", 64'(rd_data), 64'hFFFF);
    run(16'h0002, 64'h0000_0000_8000_0000, 'h2666, 0, 1);
    #1; rd_addr = 2'd0; #1;
    chk("single_edge_rank", 64'(rd_data), 64'h24CC);
    run(16'h0002, 64'h0000_0000_8000_0000, 'h2666, 0, 0);

    for (int t = 0; t < 12; t++)
      run(NN'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 'h300)), int'($urandom_range(0, 6)));

    // restart while busy is ignored; reset mid-run aborts with no done
    @(negedge clk);
    adjacency = '1; weights = {4{16'h4000}}; damping = 16'h2666; tol = '0; max_iter = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("restart_ignored_iter", 64'(iter_count), 64'd1);
    chk("restart_ignored_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_iter", 64'(iter_count), 64'd0);
    for (int i = 0; i < N; i++) begin
      rd_addr = IW'(i);
      #1;
      chk("abort_rank", 64'(rd_data), 64'h4000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    chk("idle_after_abort", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
